// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serializer through a launch/handshake FSM.
// Define UART_TX_FIFO_OVERFLOW_EN to enable the sticky o_Overflow flag (tied low otherwise).
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_En,
    input  logic [7:0]             i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Overflow,
    input  logic                   i_Clr_Ovf,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACTIVE,
        S_WAIT_DONE
    } state_t;

    logic [7:0]    r_Mem [DEPTH];
    logic [AW-1:0] r_Wr_Ptr;
    logic [AW-1:0] r_Rd_Ptr;
    logic [CW-1:0] r_Count;
    logic [7:0]    r_Tx_Byte;
    state_t        r_State;
    state_t        w_Next_State;
    logic          w_Full;
    logic          w_Empty;
    logic          w_Wr_Accept;
    logic          w_Pop;
    logic          w_Tx_DV;

    assign w_Full      = (r_Count == CW'(DEPTH));
    assign w_Empty     = (r_Count == '0);
    assign w_Wr_Accept = i_Wr_En && !w_Full;

    assign o_Full    = w_Full;
    assign o_Empty   = w_Empty;
    assign o_Count   = r_Count;
    assign o_Tx_DV   = w_Tx_DV;
    assign o_Tx_Byte = r_Tx_Byte;

    always_ff @(posedge i_Clock) begin
        if (w_Wr_Accept) begin
            r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
        end
    end

    // The pop happens on the IDLE->LAUNCH edge so the byte is already held when DV rises.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Wr_Ptr  <= '0;
            r_Rd_Ptr  <= '0;
            r_Count   <= '0;
            r_Tx_Byte <= '0;
        end else begin
            if (w_Wr_Accept) begin
                r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
            end
            if (w_Pop) begin
                r_Rd_Ptr  <= r_Rd_Ptr + AW'(1);
                r_Tx_Byte <= r_Mem[r_Rd_Ptr];
            end
            case ({w_Wr_Accept, w_Pop})
                2'b10:   r_Count <= r_Count + CW'(1);
                2'b01:   r_Count <= r_Count - CW'(1);
                default: r_Count <= r_Count;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_Next_State;
        end
    end

    // Launch only when the serializer is fully quiet; it has no reset of its own.
    always_comb begin
        w_Next_State = r_State;
        w_Pop        = 1'b0;
        w_Tx_DV      = 1'b0;
        case (r_State)
            S_IDLE: begin
                if (!w_Empty && !i_Tx_Active && !i_Tx_Done) begin
                    w_Next_State = S_LAUNCH;
                    w_Pop        = 1'b1;
                end
            end
            S_LAUNCH: begin
                w_Tx_DV      = 1'b1;
                w_Next_State = S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
                if (i_Tx_Active) begin
                    w_Next_State = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    w_Next_State = S_IDLE;
                end
            end
            default: w_Next_State = S_IDLE;
        endcase
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic r_Overflow;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Overflow <= 1'b0;
        end else if (i_Wr_En && w_Full) begin
            r_Overflow <= 1'b1;
        end else if (i_Clr_Ovf) begin
            r_Overflow <= 1'b0;
        end
    end

    assign o_Overflow = r_Overflow;
`else
    logic w_unused_clr_ovf;

    assign w_unused_clr_ovf = i_Clr_Ovf;
    assign o_Overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus for uart_tx_fifo against a queue model,
// with a behavioural serializer (no reset) driving i_Tx_Active/i_Tx_Done.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_byte;
    logic          clr_ovf;
    logic          man_act;
    logic          ser_act;
    logic          ser_done;
    logic          tx_act;
    logic          tx_done;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic [CW-1:0] count;

    assign tx_act  = ser_act | man_act;
    assign tx_done = ser_done;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_En     (wr_en),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (ovf),
        .i_Clr_Ovf   (clr_ovf),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_act),
        .i_Tx_Done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: bytes accepted but not yet launched, in arrival order.
    logic [7:0] exp_q[$];
    logic [7:0] last_byte  = 8'h00;
    logic       exp_ovf    = 1'b0;
    logic       prev_dv    = 1'b0;
    int         dv_count   = 0;
    int         accepted   = 0;
    int         flushed    = 0;
    int         ser_phase  = 0;
    int         ser_cnt    = 0;
    int         bit_clks   = 2;
    int         done_len   = 1;

    initial begin
        ser_act  = 1'b0;
        ser_done = 1'b0;
    end

    always @(negedge clk) begin
        logic drop;
        if (rst) begin
            flushed += exp_q.size();
            exp_q.delete();
            exp_ovf   = 1'b0;
            last_byte = 8'h00;
            check_eq("rst_dv",    32'(tx_dv),   32'd0);
            check_eq("rst_byte",  32'(tx_byte), 32'd0);
            check_eq("rst_count", 32'(count),   32'd0);
            check_eq("rst_empty", 32'(empty),   32'd1);
            check_eq("rst_full",  32'(full),    32'd0);
            check_eq("rst_ovf",   32'(ovf),     32'd0);
        end else begin
            if (tx_dv) begin
                check_eq("dv_ser_quiet", 32'({tx_act, tx_done}), 32'd0);
                check_eq("dv_single",    32'(prev_dv), 32'd0);
                check_eq("dv_pending",   32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) last_byte = exp_q.pop_front();
                dv_count++;
            end
            check_eq("tx_byte", 32'(tx_byte), 32'(last_byte));
            check_eq("count",   32'(count),   32'(exp_q.size()));
            check_eq("empty",   32'(empty),   32'(exp_q.size() == 0));
            check_eq("full",    32'(full),    32'(exp_q.size() == DEPTH));
            check_eq("ovf",     32'(ovf),     32'(exp_ovf));
            drop = wr_en && (exp_q.size() >= DEPTH);
            if (wr_en && !drop) begin
                exp_q.push_back(wr_byte);
                accepted++;
            end
            if (OVF_EN) begin
                if (drop) exp_ovf = 1'b1;
                else if (clr_ovf) exp_ovf = 1'b0;
            end
        end
        prev_dv = tx_dv;
        case (ser_phase)
            0: if (tx_dv) begin
                ser_phase = 1;
                ser_cnt   = bit_clks * 10;
                ser_act   = 1'b1;
            end
            1: begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    ser_act   = 1'b0;
                    ser_done  = 1'b1;
                    ser_cnt   = done_len;
                    ser_phase = 2;
                end
            end
            default: begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    ser_done  = 1'b0;
                    ser_phase = 0;
                end
            end
        endcase
    end

    task automatic drive(input logic en, input logic [7:0] b, input logic clr);
        @(posedge clk);
        #1;
        wr_en   = en;
        wr_byte = b;
        clr_ovf = clr;
    endtask

    task automatic set_busy(input logic v);
        @(posedge clk);
        #1;
        man_act = v;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || ser_phase != 0) && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("idle_reached", 32'(exp_q.size() + ser_phase), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dv0;
        int acc0;
        int iter;
        int n;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_byte = 8'h00;
        clr_ovf = 1'b0;
        man_act = 1'b0;
        #1;
        check_eq("init_empty", 32'(empty), 32'd1);
        check_eq("init_count", 32'(count), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single byte latency: DV in the 2nd cycle after the write edge.
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("lat_c1_dv",    32'(tx_dv),   32'd0);
        check_eq("lat_c1_count", 32'(count),   32'd1);
        @(negedge clk);
        check_eq("lat_c2_dv",    32'(tx_dv),   32'd1);
        check_eq("lat_c2_byte",  32'(tx_byte), 32'hA5);
        check_eq("lat_c2_count", 32'(count),   32'd0);
        @(negedge clk);
        check_eq("lat_c3_dv",    32'(tx_dv),   32'd0);
        wait_idle(500);

        // Burst of 16 while busy, then drain at 87 clocks/bit.
        dv0 = dv_count;
        set_busy(1'b1);
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("burst_full",  32'(full),  32'd1);
        check_eq("burst_count", 32'(count), 32'd16);
        bit_clks = 87;
        set_busy(1'b0);
        wait_idle(20000);
        check_eq("burst_dv", 32'(dv_count - dv0), 32'd16);
        check_eq("burst_last", 32'(tx_byte), 32'h0F);

        // Overflow: 17th write dropped; set wins over clear; clear alone clears.
        bit_clks = 2;
        set_busy(1'b1);
        for (int i = 0; i < 17; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("ovf_set",   32'(ovf),   32'(OVF_EN));
        check_eq("ovf_count", 32'(count), 32'd16);
        drive(1'b1, 8'hEE, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("ovf_set_wins", 32'(ovf), 32'(OVF_EN));
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("ovf_clr", 32'(ovf), 32'd0);
        set_busy(1'b0);
        wait_idle(2000);

        // Two-cycle Done: no relaunch during either Done cycle.
        dv0      = dv_count;
        bit_clks = 1;
        done_len = 2;
        set_busy(1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        set_busy(1'b0);
        wait_idle(1000);
        check_eq("done2_dv", 32'(dv_count - dv0), 32'd4);

        // Reset mid-byte while the serializer keeps running.
        dv0      = dv_count;
        bit_clks = 3;
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b1, 8'hC3, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        n = 0;
        while (!ser_act && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_now_dv",    32'(tx_dv),   32'd0);
        check_eq("rst_now_byte",  32'(tx_byte), 32'd0);
        check_eq("rst_now_count", 32'(count),   32'd0);
        check_eq("rst_now_empty", 32'(empty),   32'd1);
        check_eq("rst_now_ovf",   32'(ovf),     32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b1, 8'h96, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("rst_hold_dv", 32'(tx_dv), 32'd0);
        wait_idle(2000);
        check_eq("rst_dv", 32'(dv_count - dv0), 32'd3);
        check_eq("rst_last", 32'(tx_byte), 32'h96);

        // Random interleaved traffic, at least 40 accepted bytes through the FIFO.
        dv0      = dv_count;
        acc0     = accepted;
        bit_clks = 1;
        iter     = 0;
        while (accepted - acc0 < 40 && iter < 3000) begin
            done_len = int'($urandom_range(1, 2));
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
            iter++;
        end
        drive(1'b0, 8'h00, 1'b0);
        wait_idle(2000);
        check_eq("rand_accepted", 32'((accepted - acc0) >= 40), 32'd1);
        check_eq("rand_dv", 32'(dv_count - dv0), 32'(accepted - acc0));

        check_eq("dv_total", 32'(dv_count + flushed), 32'(accepted));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
